// File: rtl/stereo_pkg.sv
// Shared stereo-pipeline types: default widths, the (best, second, index)
// cost record and the pairwise merge used by every winner-take-all stage.
package stereo_pkg;

  localparam int unsigned WS_W   = 14;
  localparam int unsigned DISP_W = 6;
  localparam int unsigned NUM_CH = 4;

  typedef logic [WS_W-1:0]   cost_t;
  typedef logic [DISP_W-1:0] disp_t;

  localparam cost_t WS_MAX = '1;

  typedef struct packed {
    cost_t best;
    cost_t second;
    disp_t idx;
  } cost_pair_t;

  function automatic cost_t min_cost(input cost_t a, input cost_t b);
    return (b < a) ? b : a;
  endfunction

  function automatic cost_t max_cost(input cost_t a, input cost_t b);
    return (b > a) ? b : a;
  endfunction

  // lo must cover the lower disparities: on equal best cost lo is kept.
  function automatic cost_pair_t merge_pair(input cost_pair_t lo, input cost_pair_t hi);
    cost_pair_t r;
    r        = (hi.best < lo.best) ? hi : lo;
    r.second = min_cost(min_cost(max_cost(lo.best, hi.best), lo.second), hi.second);
    return r;
  endfunction

endpackage

// File: rtl/min_tree.sv
// Combinational NUM_CH-input winner-take-all tree. Produces the beat-local
// best cost, its channel index and the second-best cost.
// Cost and index widths are carried in the shared record, so WS_W must not
// exceed the package cost width.
module min_tree #(
  parameter int unsigned NUM_CH = stereo_pkg::NUM_CH,
  parameter int unsigned WS_W   = stereo_pkg::WS_W
) (
  input  logic [NUM_CH*WS_W-1:0] ws,
  output stereo_pkg::cost_pair_t result
);
  import stereo_pkg::*;

  localparam int unsigned LEAVES = 2 ** $clog2(NUM_CH);
  localparam int unsigned NODES  = 2 * LEAVES - 1;

  // Heap-ordered tree: node n has children 2n+1 (lower disparities) and 2n+2.
  // Unused leaves carry all-ones cost and sit to the right, so they never win.
  always_comb begin
    cost_pair_t node [NODES];
    for (int unsigned n = 0; n < NODES; n++) begin
      node[n].best   = cost_t'({WS_W{1'b1}});
      node[n].second = cost_t'({WS_W{1'b1}});
      node[n].idx    = '0;
    end
    for (int unsigned c = 0; c < NUM_CH; c++) begin
      node[LEAVES-1+c].best = cost_t'(ws[c*WS_W +: WS_W]);
      node[LEAVES-1+c].idx  = disp_t'(c);
    end
    for (int n = int'(LEAVES) - 2; n >= 0; n--) begin
      node[n] = merge_pair(node[2*n+1], node[2*n+2]);
    end
    result = node[0];
  end

endmodule

// File: rtl/disparity_select.sv
// Multi-beat winner-take-all disparity selector. Reduces NUM_CH window sums
// per beat, accumulates best/second-best over NUM_PASSES beats and emits the
// winning disparity with a uniqueness-based reliability flag.
module disparity_select #(
  parameter int unsigned NUM_CH     = stereo_pkg::NUM_CH,
  parameter int unsigned NUM_PASSES = 4,
  parameter int unsigned WS_W       = stereo_pkg::WS_W,
  parameter int unsigned DISP_W     = stereo_pkg::DISP_W,
  parameter int unsigned UNIQ_SHIFT = 3
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   in_valid,
  input  logic                   in_first,
  input  logic [NUM_CH*WS_W-1:0] ws,
  input  logic                   uniq_en,
  output logic                   out_valid,
  output logic [DISP_W-1:0]      out_disparity,
  output logic [WS_W-1:0]        out_window_sum,
  output logic                   out_reliable,
  output logic                   error
);
  import stereo_pkg::*;

  localparam int unsigned    CNT_W     = $clog2(NUM_PASSES) + 1;
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(NUM_PASSES - 1);
  localparam bit             SINGLE    = (NUM_CH * NUM_PASSES == 1);

  logic [CNT_W-1:0] pass_cnt;
  logic [CNT_W-1:0] beat_idx;
  logic             fwd;
  logic             is_last;
  logic             proto_err;
  cost_pair_t       beat_pair;
  cost_pair_t       beat_abs;

  logic             s1_valid;
  logic             s1_first;
  logic             s1_last;
  logic             s1_uniq;
  cost_pair_t       s1_pair;

  cost_pair_t       acc;
  cost_pair_t       merged;
  logic             acc_done;
  logic             acc_uniq;

  logic [WS_W:0]    margin_sum;
  logic             reliable;

  min_tree #(
    .NUM_CH (NUM_CH),
    .WS_W   (WS_W)
  ) u_min_tree (
    .ws     (ws),
    .result (beat_pair)
  );

  // Input qualification: a first beat always restarts the pixel; a non-first
  // beat is only accepted while a pixel is open.
  always_comb begin
    beat_idx     = in_first ? '0 : pass_cnt;
    is_last      = (beat_idx == LAST_BEAT);
    fwd          = in_valid && (in_first || (pass_cnt != '0));
    proto_err    = in_valid && (in_first ? (pass_cnt != '0) : (pass_cnt == '0));
    beat_abs     = beat_pair;
    beat_abs.idx = beat_pair.idx + disp_t'(beat_idx) * disp_t'(NUM_CH);
  end

  // Pass counter: position of the next expected beat within the pixel.
  always_ff @(posedge clock) begin
    if (reset) begin
      pass_cnt <= '0;
    end else if (fwd) begin
      pass_cnt <= is_last ? '0 : beat_idx + CNT_W'(1);
    end
  end

  // Protocol-violation pulse, one cycle after the offending beat.
  always_ff @(posedge clock) begin
    if (reset) begin
      error <= 1'b0;
    end else begin
      error <= proto_err;
    end
  end

  // Stage 1: register the beat reduction with its framing flags.
  always_ff @(posedge clock) begin
    if (reset) begin
      s1_valid <= 1'b0;
      s1_first <= 1'b0;
      s1_last  <= 1'b0;
      s1_uniq  <= 1'b0;
      s1_pair  <= '0;
    end else begin
      s1_valid <= fwd;
      if (fwd) begin
        s1_first <= in_first;
        s1_last  <= is_last;
        s1_uniq  <= uniq_en;
        s1_pair  <= beat_abs;
      end
    end
  end

  // Earlier beats hold lower disparities, so the accumulator is the "lo" side.
  always_comb begin
    merged = s1_first ? s1_pair : merge_pair(acc, s1_pair);
  end

  // Stage 2: running best/second-best across the beats of a pixel.
  always_ff @(posedge clock) begin
    if (reset) begin
      acc      <= '0;
      acc_done <= 1'b0;
      acc_uniq <= 1'b0;
    end else begin
      acc_done <= s1_valid && s1_last;
      if (s1_valid) begin
        acc      <= merged;
        acc_uniq <= s1_uniq;
      end
    end
  end

  // Uniqueness test at WS_W+1 bits so the margin add cannot wrap.
  always_comb begin
    margin_sum = (WS_W+1)'(acc.best[WS_W-1:0]) + (WS_W+1)'(acc.best[WS_W-1:0] >> UNIQ_SHIFT);
    reliable   = !acc_uniq || SINGLE || (margin_sum < (WS_W+1)'(acc.second[WS_W-1:0]));
  end

  // Output registers: load on pixel completion, hold otherwise.
  always_ff @(posedge clock) begin
    if (reset) begin
      out_valid      <= 1'b0;
      out_disparity  <= '0;
      out_window_sum <= '0;
      out_reliable   <= 1'b0;
    end else begin
      out_valid <= acc_done;
      if (acc_done) begin
        out_disparity  <= acc.idx[DISP_W-1:0];
        out_window_sum <= acc.best[WS_W-1:0];
        out_reliable   <= reliable;
      end
    end
  end

endmodule

// File: tb/tb_disparity_select.sv
// Scoreboard bench for disparity_select with 4 channels x 4 passes.
module tb_disparity_select;

  localparam int NUM_CH     = 4;
  localparam int NUM_PASSES = 4;
  localparam int WS_W       = 14;
  localparam int DISP_W     = 6;
  localparam int UNIQ_SHIFT = 3;
  localparam int NDISP      = NUM_CH * NUM_PASSES;

  typedef int pix_t [NDISP];
  typedef struct {
    int disp;
    int cost;
    bit rel;
  } exp_t;

  logic                   clock = 1'b0;
  logic                   reset;
  logic                   in_valid;
  logic                   in_first;
  logic [NUM_CH*WS_W-1:0] ws;
  logic                   uniq_en;
  logic                   out_valid;
  logic [DISP_W-1:0]      out_disparity;
  logic [WS_W-1:0]        out_window_sum;
  logic                   out_reliable;
  logic                   error;

  int   n_cmp = 0;
  int   n_bad = 0;
  int   n_outs = 0;
  int   cyc = 0;
  exp_t sb [$];
  int   out_cyc [$];

  disparity_select #(
    .NUM_CH     (NUM_CH),
    .NUM_PASSES (NUM_PASSES),
    .WS_W       (WS_W),
    .DISP_W     (DISP_W),
    .UNIQ_SHIFT (UNIQ_SHIFT)
  ) dut (
    .clock          (clock),
    .reset          (reset),
    .in_valid       (in_valid),
    .in_first       (in_first),
    .ws             (ws),
    .uniq_en        (uniq_en),
    .out_valid      (out_valid),
    .out_disparity  (out_disparity),
    .out_window_sum (out_window_sum),
    .out_reliable   (out_reliable),
    .error          (error)
  );

  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  // Reference model: first minimum wins, second is the smallest remaining cost.
  function automatic exp_t model(input pix_t c, input bit u);
    exp_t e;
    int b, bi, s;
    b  = c[0];
    bi = 0;
    for (int i = 1; i < NDISP; i++) if (c[i] < b) begin b = c[i]; bi = i; end
    s = (1 << WS_W) - 1;
    for (int i = 0; i < NDISP; i++) if (i != bi && c[i] < s) s = c[i];
    e.disp = bi;
    e.cost = b;
    e.rel  = !u || ((b + (b >> UNIQ_SHIFT)) < s);
    return e;
  endfunction

  function automatic logic [NUM_CH*WS_W-1:0] pack_beat(input pix_t c, input int k);
    logic [NUM_CH*WS_W-1:0] w;
    logic [31:0] v;
    w = '0;
    for (int ch = 0; ch < NUM_CH; ch++) begin
      v = c[k*NUM_CH + ch];
      w[ch*WS_W +: WS_W] = v[WS_W-1:0];
    end
    return w;
  endfunction

  function automatic pix_t fill(input int v);
    pix_t c;
    for (int i = 0; i < NDISP; i++) c[i] = v;
    return c;
  endfunction

  // Scoreboard monitor: every result strobe must match the oldest expectation.
  always @(negedge clock) begin
    if (out_valid) begin
      exp_t e;
      n_outs++;
      out_cyc.push_back(cyc);
      n_cmp++;
      if (sb.size() == 0) begin
        n_bad++;
        $display("FAIL unexpected_out: got disp=%0d cost=%0d rel=%0d, expected no result",
                 out_disparity, out_window_sum, out_reliable);
      end else begin
        e = sb.pop_front();
        if ({out_disparity, out_window_sum, out_reliable} !==
            {DISP_W'(e.disp), WS_W'(e.cost), e.rel}) begin
          n_bad++;
          $display("FAIL result: got disp=%0d cost=%0d rel=%0d, expected disp=%0d cost=%0d rel=%0d",
                   out_disparity, out_window_sum, out_reliable, e.disp, e.cost, e.rel);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // All drive tasks start and end 1ns after a rising edge.
  task automatic drive_beat(input logic [NUM_CH*WS_W-1:0] w, input bit first, input bit u);
    in_valid = 1'b1;
    in_first = first;
    ws       = w;
    uniq_en  = u;
    @(posedge clock); #1;
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    in_first = 1'b0;
    repeat (n) begin @(posedge clock); #1; end
  endtask

  // uniq_en only matters on the last beat; earlier beats carry the opposite value.
  task automatic send_pixel(input pix_t c, input bit u, input int gap);
    sb.push_back(model(c, u));
    for (int k = 0; k < NUM_PASSES; k++) begin
      drive_beat(pack_beat(c, k), k == 0, (k == NUM_PASSES-1) ? u : !u);
      if (gap > 0 && k < NUM_PASSES-1) idle(gap);
    end
    in_valid = 1'b0;
    in_first = 1'b0;
  endtask

  task automatic wait_drain(input string name);
    int k = 0;
    while (sb.size() != 0 && k < 40) begin @(posedge clock); #1; k++; end
    n_cmp++;
    if (sb.size() != 0) begin
      n_bad++;
      $display("FAIL %s_timeout: %0d results outstanding, expected 0", name, sb.size());
      sb.delete();
    end
  endtask

  task automatic test_reset;
    n_cmp++;
    if ({out_valid, error, out_reliable, out_disparity, out_window_sum} !== '0) begin
      n_bad++;
      $display("FAIL reset_outputs: got v=%0d err=%0d rel=%0d disp=%0d cost=%0d, expected all 0",
               out_valid, error, out_reliable, out_disparity, out_window_sum);
    end
  endtask

  task automatic test_min_middle;
    pix_t c;
    logic [2:0] seen;
    c = fill(500);
    c[9]  = 100;
    c[14] = 200;
    send_pixel(c, 1'b1, 0);
    seen[2] = out_valid;
    @(posedge clock); #1; seen[1] = out_valid;
    @(posedge clock); #1; seen[0] = out_valid;
    n_cmp++;
    if (seen !== 3'b001) begin
      n_bad++;
      $display("FAIL latency: got out_valid pattern %b after last beat, expected 001", seen);
    end
    wait_drain("min_middle");
    idle(2);
  endtask

  task automatic test_tie;
    pix_t c;
    c = fill(900);
    c[3]  = 50;
    c[12] = 50;
    send_pixel(c, 1'b1, 0);
    wait_drain("tie");
    idle(2);
  endtask

  task automatic test_uniqueness;
    pix_t c;
    c = fill(1000);
    c[5]  = 160;
    c[11] = 170;
    send_pixel(c, 1'b1, 0);
    wait_drain("uniq_low");
    send_pixel(c, 1'b0, 0);
    wait_drain("uniq_off");
    c[11] = 181;
    send_pixel(c, 1'b1, 0);
    wait_drain("uniq_high");
    idle(2);
  endtask

  task automatic test_protocol_first;
    pix_t a, b;
    int outs0;
    a = fill(10);
    b = fill(700);
    b[6]  = 300;
    b[13] = 320;
    outs0 = n_outs;
    drive_beat(pack_beat(a, 0), 1'b1, 1'b1);
    drive_beat(pack_beat(a, 1), 1'b0, 1'b1);
    sb.push_back(model(b, 1'b1));
    drive_beat(pack_beat(b, 0), 1'b1, 1'b0);
    n_cmp++;
    if (error !== 1'b1) begin
      n_bad++;
      $display("FAIL first_mid_error: got error=%b, expected 1", error);
    end
    drive_beat(pack_beat(b, 1), 1'b0, 1'b0);
    n_cmp++;
    if (error !== 1'b0) begin
      n_bad++;
      $display("FAIL first_mid_error_len: got error=%b, expected 0", error);
    end
    drive_beat(pack_beat(b, 2), 1'b0, 1'b0);
    drive_beat(pack_beat(b, 3), 1'b0, 1'b1);
    idle(0);
    wait_drain("first_mid");
    idle(3);
    n_cmp++;
    if (n_outs - outs0 !== 1) begin
      n_bad++;
      $display("FAIL first_mid_count: got %0d results, expected 1", n_outs - outs0);
    end
  endtask

  task automatic test_orphan;
    pix_t c;
    int outs0;
    c = fill(42);
    outs0 = n_outs;
    drive_beat(pack_beat(c, 0), 1'b0, 1'b1);
    in_valid = 1'b0;
    n_cmp++;
    if (error !== 1'b1) begin
      n_bad++;
      $display("FAIL orphan_error: got error=%b, expected 1", error);
    end
    idle(6);
    n_cmp++;
    if ({n_outs - outs0, 1'b0} !== {0, error}) begin
      n_bad++;
      $display("FAIL orphan_quiet: got %0d results error=%b, expected 0 results error=0",
               n_outs - outs0, error);
    end
  endtask

  task automatic test_reset_mid;
    pix_t c;
    int outs0;
    c = fill(11);
    outs0 = n_outs;
    drive_beat(pack_beat(c, 0), 1'b1, 1'b1);
    drive_beat(pack_beat(c, 1), 1'b0, 1'b1);
    in_valid = 1'b0;
    reset = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0;
    idle(6);
    n_cmp++;
    if (n_outs - outs0 !== 0) begin
      n_bad++;
      $display("FAIL reset_mid_quiet: got %0d results, expected 0", n_outs - outs0);
    end
    c = fill(700);
    c[0] = 20;
    c[7] = 400;
    send_pixel(c, 1'b1, 0);
    wait_drain("reset_mid");
    idle(2);
  endtask

  task automatic test_gaps;
    pix_t c;
    c = fill(500);
    c[9]  = 100;
    c[14] = 200;
    send_pixel(c, 1'b1, 3);
    wait_drain("gaps");
    idle(2);
  endtask

  task automatic test_back_to_back;
    pix_t c;
    int first_idx;
    first_idx = out_cyc.size();
    for (int p = 0; p < 4; p++) begin
      for (int i = 0; i < NDISP; i++) c[i] = int'($urandom_range(0, 400));
      send_pixel(c, p[0], 0);
    end
    wait_drain("b2b");
    idle(2);
    n_cmp++;
    if (out_cyc.size() - first_idx !== 4) begin
      n_bad++;
      $display("FAIL b2b_count: got %0d results, expected 4", out_cyc.size() - first_idx);
    end else begin
      for (int i = first_idx + 1; i < first_idx + 4; i++) begin
        n_cmp++;
        if (out_cyc[i] - out_cyc[i-1] !== NUM_PASSES) begin
          n_bad++;
          $display("FAIL b2b_spacing: got %0d cycles between results, expected %0d",
                   out_cyc[i] - out_cyc[i-1], NUM_PASSES);
        end
      end
    end
  endtask

  initial begin
    reset    = 1'b1;
    in_valid = 1'b0;
    in_first = 1'b0;
    ws       = '0;
    uniq_en  = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    test_reset();
    reset = 1'b0;
    idle(2);
    test_min_middle();
    test_tie();
    test_uniqueness();
    test_protocol_first();
    test_orphan();
    test_reset_mid();
    test_gaps();
    test_back_to_back();
    idle(5);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
